// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus for the program loader.
// master = stream source / system side, slave = the loader itself.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_halt;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   bytes_loaded;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_halt, load_done, load_error, bytes_loaded
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output cpu_halt, load_done, load_error, bytes_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives <len> <data...> <checksum> over a valid/ready byte
// stream, writes the data into instruction memory from address 0 and keeps
// the processor halted until the 8-bit additive checksum matches.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 256
) (
  input  logic            clock,
  input  logic            reset_n,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // A length byte of zero encodes a full image.
  localparam logic [ADDR_W:0] FULL_LEN  = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0]   bytes_loaded;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_halt;
  logic              load_done;
  logic              load_error;

  logic              accept;
  logic [ADDR_W:0]   next_count;

  // Running checksum is a plain modulo-2^DATA_W sum.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Map the length byte onto an image size, zero meaning MAX_LEN.
  function automatic logic [ADDR_W:0] decode_len(input logic [DATA_W-1:0] b);
    if (b == '0) return FULL_LEN;
    return (ADDR_W + 1)'(b);
  endfunction

  assign accept     = bus.byte_valid && byte_ready;
  assign next_count = bytes_loaded + COUNT_ONE;

  // Loader FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      len          <= '0;
      sum          <= '0;
      bytes_loaded <= '0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_halt     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse following a data acceptance.
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state        <= LEN;
            byte_ready   <= 1'b1;
            cpu_halt     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            sum          <= '0;
            bytes_loaded <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            len   <= decode_len(bus.byte_in);
            state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            imem_we      <= 1'b1;
            imem_addr    <= bytes_loaded[ADDR_W-1:0];
            imem_wdata   <= bus.byte_in;
            bytes_loaded <= next_count;
            sum          <= csum_add(sum, bus.byte_in);
            if (next_count == len) state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (bus.byte_in == sum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_halt  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_halt   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.imem_we      = imem_we;
  assign bus.imem_addr    = imem_addr;
  assign bus.imem_wdata   = imem_wdata;
  assign bus.cpu_halt     = cpu_halt;
  assign bus.load_done    = load_done;
  assign bus.load_error   = load_error;
  assign bus.bytes_loaded = bytes_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed image loads with a write scoreboard.
module tb_program_loader;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  program_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  program_loader #(.ADDR_W(8), .DATA_W(8), .MAX_LEN(256)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          w0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [7:0]  img[256];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: every write pulse must match the next expected (addr,data).
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        check("imem_write", 32'({bus.imem_addr, bus.imem_wdata}), 32'(exp_w));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n    = 0;
    bit took = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!took && n < 50) begin
      @(negedge clock);
      took = (bus.byte_ready === 1'b1);
      @(posedge clock);
      #1;
      n++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no byte_ready for 0x%0h, want acceptance", b);
    end
  endtask

  task automatic gap();
    bus.byte_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Sends length, img[0..n-1] and checksum; queues the expected writes.
  task automatic load(input logic [7:0] len_b, input int n,
                      input logic [7:0] cs, input bit gaps);
    send(len_b);
    if (gaps) gap();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), img[i]});
      send(img[i]);
      if (gaps) gap();
    end
    send(cs);
    bus.byte_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_cpu_halt",     32'(bus.cpu_halt),     32'd1);
    check("rst_byte_ready",   32'(bus.byte_ready),   32'd0);
    check("rst_imem_we",      32'(bus.imem_we),      32'd0);
    check("rst_load_done",    32'(bus.load_done),    32'd0);
    check("rst_load_error",   32'(bus.load_error),   32'd0);
    check("rst_bytes_loaded", 32'(bus.bytes_loaded), 32'd0);
    check("rst_imem_addr",    32'(bus.imem_addr),    32'd0);
    check("rst_imem_wdata",   32'(bus.imem_wdata),   32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic 3-byte load; length byte presented together with start.
    img[0] = 8'h41; img[1] = 8'h82; img[2] = 8'h1C;
    w0 = writes;
    bus.byte_in    = 8'h03;
    bus.byte_valid = 1'b1;
    pulse_start();
    check("start_byte_ready",   32'(bus.byte_ready),   32'd1);
    check("start_bytes_loaded", 32'(bus.bytes_loaded), 32'd0);
    load(8'h03, 3, 8'hDF, 1'b0);
    check("basic_done",   32'(bus.load_done),    32'd1);
    check("basic_error",  32'(bus.load_error),   32'd0);
    check("basic_halt",   32'(bus.cpu_halt),     32'd0);
    check("basic_ready",  32'(bus.byte_ready),   32'd0);
    check("basic_count",  32'(bus.bytes_loaded), 32'd3);
    check("basic_writes", 32'(writes - w0),      32'd3);

    // Same image, bad checksum.
    w0 = writes;
    pulse_start();
    check("restart_done_clr",  32'(bus.load_done),    32'd0);
    check("restart_count_clr", 32'(bus.bytes_loaded), 32'd0);
    check("restart_halt",      32'(bus.cpu_halt),     32'd1);
    load(8'h03, 3, 8'hDE, 1'b0);
    check("bad_error",  32'(bus.load_error),   32'd1);
    check("bad_done",   32'(bus.load_done),    32'd0);
    check("bad_halt",   32'(bus.cpu_halt),     32'd1);
    check("bad_ready",  32'(bus.byte_ready),   32'd0);
    check("bad_count",  32'(bus.bytes_loaded), 32'd3);
    check("bad_writes", 32'(writes - w0),      32'd3);

    // Throttled source: valid on every other cycle.
    img[0] = 8'hFF; img[1] = 8'h02;
    w0 = writes;
    pulse_start();
    load(8'h02, 2, 8'h01, 1'b1);
    check("thr_done",   32'(bus.load_done), 32'd1);
    check("thr_error",  32'(bus.load_error), 32'd0);
    check("thr_writes", 32'(writes - w0),   32'd2);

    // Full 256-byte image, data = address.
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    w0 = writes;
    pulse_start();
    load(8'h00, 256, 8'h80, 1'b0);
    check("full_done",   32'(bus.load_done),    32'd1);
    check("full_halt",   32'(bus.cpu_halt),     32'd0);
    check("full_count",  32'(bus.bytes_loaded), 32'd256);
    check("full_writes", 32'(writes - w0),      32'd256);

    // start pulsed in DATA is ignored.
    img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h30;
    w0 = writes;
    pulse_start();
    send(8'h03);
    exp_q.push_back({8'h00, img[0]});
    send(img[0]);
    bus.byte_valid = 1'b0;
    pulse_start();
    check("mid_start_count", 32'(bus.bytes_loaded), 32'd1);
    check("mid_start_ready", 32'(bus.byte_ready),   32'd1);
    exp_q.push_back({8'h01, img[1]});
    send(img[1]);
    exp_q.push_back({8'h02, img[2]});
    send(img[2]);
    send(8'h60);
    bus.byte_valid = 1'b0;
    @(posedge clock);
    #1;
    check("mid_start_done",   32'(bus.load_done),    32'd1);
    check("mid_start_final",  32'(bus.bytes_loaded), 32'd3);
    check("mid_start_writes", 32'(writes - w0),      32'd3);

    // Reset in the middle of a load, right as the second write pulses.
    w0 = writes;
    pulse_start();
    send(8'h05);
    exp_q.push_back({8'h00, 8'hAA});
    send(8'hAA);
    send(8'hBB);
    check("prerst_we", 32'(bus.imem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    bus.byte_valid = 1'b0;
    check("arst_we",    32'(bus.imem_we),      32'd0);
    check("arst_ready", 32'(bus.byte_ready),   32'd0);
    check("arst_done",  32'(bus.load_done),    32'd0);
    check("arst_halt",  32'(bus.cpu_halt),     32'd1);
    check("arst_count", 32'(bus.bytes_loaded), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("arst_idle_ready", 32'(bus.byte_ready), 32'd0);
    check("arst_writes",     32'(writes - w0),    32'd1);
    img[0] = 8'h07;
    w0 = writes;
    pulse_start();
    load(8'h01, 1, 8'h07, 1'b0);
    check("reload_done",   32'(bus.load_done),    32'd1);
    check("reload_count",  32'(bus.bytes_loaded), 32'd1);
    check("reload_writes", 32'(writes - w0),      32'd1);

    @(posedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
